// File: rtl/rgb_panel_oe_ctrl_if.sv
// Handshake bundle between the serial-to-panel stage, the OE controller and
// the LED panel.
//   latch_in : latch pulse from the serial-to-panel stage (asynchronous to clk)
//   row_in   : row address from the serial-to-panel stage
//   enable   : display enable, low forces blanking
//   oe_n     : panel output enable, active-low
//   lat_out  : panel latch strobe, one clk wide
//   row_out  : panel row address
//   plane    : bit plane currently displayed
//   busy     : controller outside IDLE
//   overrun  : one-cycle pulse when a latch event is dropped
// master drives the inputs and observes the outputs; slave is the controller.
interface rgb_panel_oe_ctrl_if;
    logic       latch_in;
    logic [3:0] row_in;
    logic       enable;
    logic       oe_n;
    logic       lat_out;
    logic [3:0] row_out;
    logic [2:0] plane;
    logic       busy;
    logic       overrun;

    modport master (
        output latch_in, row_in, enable,
        input  oe_n, lat_out, row_out, plane, busy, overrun
    );

    modport slave (
        input  latch_in, row_in, enable,
        output oe_n, lat_out, row_out, plane, busy, overrun
    );
endinterface

// File: rtl/rgb_panel_oe_ctrl.sv
// Panel output-enable / latch sequencer with binary-coded-modulation on-times.
// Each accepted latch event runs: BLANK_PRE (BLANK_CYCLES) -> LATCH (1) ->
// BLANK_POST (BLANK_CYCLES) -> ON (BASE_ON << plane) -> IDLE, advancing the
// bit plane whenever ON is left by expiry or by a preempting event.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : rgb_panel_oe_ctrl_if.slave (latch_in/row_in/enable in,
//           oe_n/lat_out/row_out/plane/busy/overrun out, all registered)
module rgb_panel_oe_ctrl #(
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned BASE_ON      = 8,
    parameter int unsigned PLANES       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rgb_panel_oe_ctrl_if.slave   bus
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned PLANE_W = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BLANK_PRE  = 3'd1,
        LATCH      = 3'd2,
        BLANK_POST = 3'd3,
        ON         = 3'd4
    } state_t;

    // Synchronizer chain and registered edge event.
    logic sync_a;
    logic sync_b;
    logic sync_c;
    logic event_q;

    state_t               state;
    logic [CNT_W-1:0]     cnt_q;
    logic [ROW_W-1:0]     row_hold;
    logic [PLANE_W-1:0]   plane_q;
    logic [ROW_W-1:0]     row_out_q;
    logic                 oe_n_q;
    logic                 lat_out_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic [CNT_W-1:0]     blank_load;
    logic [CNT_W-1:0]     on_load;
    logic [PLANE_W-1:0]   plane_next;

    // Two flops retime latch_in, a third holds the previous sample for edge
    // detect; the event itself is registered so it lands 3 cycles after the
    // cycle in which latch_in rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            sync_c  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            sync_a  <= bus.latch_in;
            sync_b  <= sync_a;
            sync_c  <= sync_b;
            event_q <= sync_b & ~sync_c;
        end
    end

    // Counter reload values; counts run down to zero, so load length-1.
    assign blank_load = CNT_W'(BLANK_CYCLES - 1);
    assign on_load    = (CNT_W'(BASE_ON) << plane_q) - CNT_W'(1);
    assign plane_next = (plane_q == PLANE_W'(PLANES - 1)) ? '0 : plane_q + PLANE_W'(1);

    // Sequencer: state, counter and all outputs registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt_q     <= '0;
            row_hold  <= '0;
            plane_q   <= '0;
            row_out_q <= '0;
            oe_n_q    <= 1'b1;
            lat_out_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            lat_out_q <= 1'b0;
            overrun_q <= 1'b0;
            if (!bus.enable) begin
                // Abort: blank and idle; plane and row_out keep their values,
                // events are ignored silently.
                state  <= IDLE;
                oe_n_q <= 1'b1;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (event_q) begin
                            state    <= BLANK_PRE;
                            cnt_q    <= blank_load;
                            row_hold <= bus.row_in;
                            busy_q   <= 1'b1;
                            oe_n_q   <= 1'b1;
                        end
                    end
                    BLANK_PRE: begin
                        if (event_q) begin
                            overrun_q <= 1'b1;
                        end
                        if (cnt_q == '0) begin
                            state     <= LATCH;
                            lat_out_q <= 1'b1;
                            row_out_q <= row_hold;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    LATCH: begin
                        if (event_q) begin
                            overrun_q <= 1'b1;
                        end
                        state <= BLANK_POST;
                        cnt_q <= blank_load;
                    end
                    BLANK_POST: begin
                        if (event_q) begin
                            overrun_q <= 1'b1;
                        end
                        if (cnt_q == '0) begin
                            state  <= ON;
                            oe_n_q <= 1'b0;
                            cnt_q  <= on_load;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ON: begin
                        // A new event outranks expiry in the same cycle; the
                        // plane advances exactly once either way.
                        if (event_q) begin
                            state    <= BLANK_PRE;
                            cnt_q    <= blank_load;
                            row_hold <= bus.row_in;
                            oe_n_q   <= 1'b1;
                            plane_q  <= plane_next;
                        end else if (cnt_q == '0) begin
                            state   <= IDLE;
                            oe_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            plane_q <= plane_next;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        oe_n_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.oe_n    = oe_n_q;
    assign bus.lat_out = lat_out_q;
    assign bus.row_out = row_out_q;
    assign bus.plane   = plane_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_rgb_panel_oe_ctrl.sv
// Bench for rgb_panel_oe_ctrl: directed scenarios with literal expectations
// plus randomized latch/enable traffic compared every cycle against a
// window-offset model (outputs derived from the distance to the last
// accepted event).
module tb_rgb_panel_oe_ctrl;

    localparam int B    = 4;
    localparam int BASE = 8;
    localparam int NP   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   cmp_en = 1'b0;

    rgb_panel_oe_ctrl_if bus ();

    rgb_panel_oe_ctrl #(
        .BLANK_CYCLES (B),
        .BASE_ON      (BASE),
        .PLANES       (NP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Cycles in which the DUT's latch event is expected (rise cycle + 3).
    bit ev_at [int];

    // Model state: one display window anchored at the accepted event cycle.
    bit         m_active = 1'b0;
    int         m_start  = 0;
    int         m_plane  = 0;
    logic [3:0] m_hold   = '0;
    logic [3:0] m_rowout = '0;
    bit         e_oe_n   = 1'b1;
    bit         e_lat    = 1'b0;
    bit         e_busy   = 1'b0;
    bit         e_ovr    = 1'b0;

    int lat_cnt = 0;
    int ovr_cnt = 0;
    int on_cnt  = 0;

    function automatic int on_len(input int p);
        return BASE << p;
    endfunction

    task automatic model_clear();
        m_active = 1'b0;
        m_start  = 0;
        m_plane  = 0;
        m_hold   = '0;
        m_rowout = '0;
        e_oe_n   = 1'b1;
        e_lat    = 1'b0;
        e_busy   = 1'b0;
        e_ovr    = 1'b0;
        ev_at.delete();
    endtask

    // Expected outputs for cycle cyc, given inputs seen during cycle cyc-1.
    task automatic model_step();
        int c, dp, d, len;
        bit ev, prev_on;
        c       = cyc;
        len     = on_len(m_plane);
        ev      = ev_at.exists(c - 1);
        dp      = (c - 1) - m_start;
        prev_on = m_active && (dp >= 2*B + 2) && (dp <= 2*B + 1 + len);
        e_ovr   = 1'b0;
        if (bus.enable !== 1'b1) begin
            m_active = 1'b0;
        end else if (ev && (!m_active || prev_on)) begin
            if (prev_on) m_plane = (m_plane + 1) % NP;
            m_active = 1'b1;
            m_start  = c - 1;
            m_hold   = bus.row_in;
        end else begin
            if (ev) e_ovr = 1'b1;
            if (m_active && (c - m_start) == 2*B + 2 + len) begin
                m_active = 1'b0;
                m_plane  = (m_plane + 1) % NP;
            end
        end
        d      = c - m_start;
        len    = on_len(m_plane);
        e_busy = m_active;
        e_lat  = m_active && (d == B + 1);
        e_oe_n = !(m_active && (d >= 2*B + 2) && (d <= 2*B + 1 + len));
        if (e_lat) m_rowout = m_hold;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) model_clear();
        else model_step();
    end

    always @(posedge reset) model_clear();

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            n_checks++;
            if ({bus.oe_n, bus.lat_out, bus.row_out, bus.plane, bus.busy, bus.overrun} !==
                {e_oe_n, e_lat, m_rowout, 3'(m_plane), e_busy, e_ovr}) begin
                n_errors++;
                $display("FAIL model cycle %0d: got oe_n=%b lat=%b row=%0d plane=%0d busy=%b ovr=%b, required oe_n=%b lat=%b row=%0d plane=%0d busy=%b ovr=%b",
                         cyc, bus.oe_n, bus.lat_out, bus.row_out, bus.plane, bus.busy, bus.overrun,
                         e_oe_n, e_lat, m_rowout, m_plane, e_busy, e_ovr);
            end
        end
    end

    // Event counters sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (bus.lat_out === 1'b1) lat_cnt++;
            if (bus.overrun === 1'b1) ovr_cnt++;
            if (bus.oe_n === 1'b0) on_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Three-cycle latch pulse; returns at the negedge of the event cycle.
    task automatic pulse(input logic [3:0] r, output int e);
        @(negedge clk);
        bus.row_in   = r;
        bus.latch_in = 1'b1;
        e = cyc + 3;
        ev_at[e] = 1'b1;
        repeat (3) @(negedge clk);
        bus.latch_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic scenario1(input string tag);
        int e;
        pulse(4'd5, e);
        wait_to(e + 4);  chk({tag, " lat before"}, bus.lat_out, 0);
        wait_to(e + 5);  chk({tag, " lat"}, bus.lat_out, 1);
                         chk({tag, " row"}, bus.row_out, 5);
                         chk({tag, " oe_n at latch"}, bus.oe_n, 1);
        wait_to(e + 9);  chk({tag, " oe_n last blank"}, bus.oe_n, 1);
        wait_to(e + 10); chk({tag, " oe_n first on"}, bus.oe_n, 0);
                         chk({tag, " plane during on"}, bus.plane, 0);
        wait_to(e + 17); chk({tag, " oe_n last on"}, bus.oe_n, 0);
        wait_to(e + 18); chk({tag, " oe_n after"}, bus.oe_n, 1);
                         chk({tag, " plane after"}, bus.plane, 1);
                         chk({tag, " busy after"}, bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int e, e1, e2, bl, bo, bn;
        int exp_on [4];
        exp_on = '{8, 16, 32, 64};
        bus.latch_in = 1'b0;
        bus.row_in   = '0;
        bus.enable   = 1'b1;
        reset        = 1'b1;
        idle_cycles(3);
        chk("reset oe_n", bus.oe_n, 1);
        chk("reset lat_out", bus.lat_out, 0);
        chk("reset row_out", bus.row_out, 0);
        chk("reset plane", bus.plane, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset overrun", bus.overrun, 0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        idle_cycles(4);

        // 1: single latch.
        scenario1("s1");
        idle_cycles(10);

        // 2: four latches 200 cycles apart, BCM on-times.
        do_reset();
        idle_cycles(3);
        for (int i = 0; i < 4; i++) begin
            chk("s2 plane before", bus.plane, i);
            bn = on_cnt;
            pulse(4'(i + 1), e);
            wait_to(e - 3 + 199);
            chk("s2 on-time", on_cnt - bn, exp_on[i]);
        end
        chk("s2 plane wrap", bus.plane, 0);

        // 3: second latch 3 cycles after the first event is dropped.
        pulse(4'd9, e1);
        wait_to(e1 + 2);
        bl = lat_cnt;
        bo = ovr_cnt;
        pulse(4'd2, e2);
        wait_to(e2 + 1); chk("s3 overrun pulse", bus.overrun, 1);
        wait_to(e2 + 2); chk("s3 overrun width", bus.overrun, 0);
        wait_to(e1 + 40);
        chk("s3 lat count", lat_cnt - bl, 1);
        chk("s3 overrun count", ovr_cnt - bo, 1);
        chk("s3 row_out", bus.row_out, 9);

        // 4: preempt 5 cycles into the plane-2 window.
        pulse(4'd3, e);
        wait_to(e + 30);
        chk("s4 plane before", bus.plane, 2);
        pulse(4'd4, e1);
        wait_to(e1 + 5);
        bn = on_cnt;
        wait_to(e1 + 10);
        pulse(4'd6, e2);
        wait_to(e2 + 1);  chk("s4 oe_n preempt", bus.oe_n, 1);
                          chk("s4 busy preempt", bus.busy, 1);
                          chk("s4 on cycles", on_cnt - bn, 5);
        wait_to(e2 + 5);  chk("s4 new row", bus.row_out, 6);
        wait_to(e2 + 10); chk("s4 oe_n new on", bus.oe_n, 0);
                          chk("s4 new plane", bus.plane, 3);
        wait_to(e2 + 80); chk("s4 plane wrap", bus.plane, 0);

        // 5: enable dropped mid-ON.
        pulse(4'd7, e);
        wait_to(e + 12);
        bus.enable = 1'b0;
        wait_to(e + 13);
        chk("s5 oe_n abort", bus.oe_n, 1);
        chk("s5 busy abort", bus.busy, 0);
        chk("s5 plane hold", bus.plane, 0);
        bl = lat_cnt;
        bo = ovr_cnt;
        pulse(4'd1, e1);
        idle_cycles(20);
        pulse(4'd2, e1);
        idle_cycles(20);
        chk("s5 no lat", lat_cnt - bl, 0);
        chk("s5 no overrun", ovr_cnt - bo, 0);
        chk("s5 row hold", bus.row_out, 7);
        bus.enable = 1'b1;
        idle_cycles(5);
        pulse(4'd8, e);
        wait_to(e + 5);  chk("s5 lat after enable", bus.lat_out, 1);
                         chk("s5 row after enable", bus.row_out, 8);
                         chk("s5 plane after enable", bus.plane, 0);
        wait_to(e + 20); chk("s5 plane advance", bus.plane, 1);

        // 6: reset during BLANK_POST, then scenario 1 again.
        pulse(4'd11, e);
        wait_to(e + 7);
        chk("s6 row before reset", bus.row_out, 11);
        #2;
        reset = 1'b1;
        #1;
        chk("s6 oe_n", bus.oe_n, 1);
        chk("s6 row_out", bus.row_out, 0);
        chk("s6 plane", bus.plane, 0);
        chk("s6 busy", bus.busy, 0);
        chk("s6 lat_out", bus.lat_out, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(5);
        scenario1("s6");
        idle_cycles(10);

        // Randomized latch and enable traffic, checked by the model.
        for (int k = 0; k < 70; k++) begin
            if ($urandom_range(0, 9) < 8) begin
                pulse(4'($urandom_range(0, 15)), e);
                idle_cycles($urandom_range(1, 70));
            end else begin
                bus.enable = 1'b0;
                idle_cycles($urandom_range(1, 25));
                bus.enable = 1'b1;
                idle_cycles($urandom_range(1, 10));
            end
        end
        idle_cycles(120);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb_panel_oe_ctrl.md
Name: rgb_panel_oe_ctrl

Overview:
Downstream of the serial-to-panel stage in the CPLD. Consumes that stage's latch pulse and row address. Generates the panel's output-enable (active-low), a retimed latch strobe and a retimed row address, with blanking around every latch. Applies binary-coded-modulation on-times across bit planes.

Parameters:
BLANK_CYCLES, 4, clk cycles of forced blanking before and after the latch strobe (1..15)
BASE_ON, 8, on-time in clk cycles for plane 0 (1..255)
PLANES, 4, number of bit planes cycled (1..8); on-time of plane p = BASE_ON << p

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
latch_in  input  1  latch pulse from the serial-to-panel stage; asynchronous to clk
row_in  input  4  row address from the serial-to-panel stage; stable >=3 clk cycles around a latch_in rising edge
enable  input  1  display enable; low forces blanking
oe_n  output  1  panel output enable, active-low
lat_out  output  1  panel latch strobe, one clk cycle wide
row_out  output  4  panel row address
plane  output  3  bit plane currently displayed
busy  output  1  high in any state other than IDLE
overrun  output  1  one-cycle pulse when a latch event is dropped

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: oe_n=1, lat_out=0, row_out=0, plane=0, busy=0, overrun=0. FSM=IDLE, synchronizer flops=0.
- Synchronizer: latch_in passes through 2 flops, then a third flop for edge detect.
- Latch event: asserts for 1 cycle (cycle E) on a synchronized 0->1 transition. row_in is captured into row_hold in cycle E.
- A latch_in rising edge produces an event 3 clk cycles later (E = T+3).
- All outputs are registered.
- FSM states: IDLE, BLANK_PRE, LATCH, BLANK_POST, ON.
  - IDLE: oe_n=1. Event -> BLANK_PRE at E+1.
  - BLANK_PRE: oe_n=1 for exactly BLANK_CYCLES cycles, then LATCH.
  - LATCH: 1 cycle; lat_out=1, row_out<=row_hold (visible the same cycle lat_out is high), oe_n=1. Then BLANK_POST.
  - BLANK_POST: oe_n=1 for BLANK_CYCLES cycles, then ON.
  - ON: oe_n=0 for exactly BASE_ON<<plane cycles, then IDLE.
- Timing summary: first oe_n=0 cycle is E+1+2*BLANK_CYCLES+1.
- On-time counter: 16 bits, sized for BASE_ON=255 and PLANES=8 (255<<7 = 32640).
- Plane advance: plane increments when ON is exited, whether completed or preempted. PLANES-1 wraps to 0. plane is stable throughout BLANK_PRE..ON.
- Event during ON (preemption): oe_n=1 at E+1, state BLANK_PRE at E+1, plane advances, row_hold is updated.
- Event during BLANK_PRE, LATCH or BLANK_POST: event dropped, overrun=1 at E+1 for one cycle. row_hold is not updated and timing is unaffected.
- Event and ON expiry in the same cycle: the event wins and is treated as preemption. plane advances once only.
- enable low:
  - oe_n=1 combinationally-registered at the next edge; FSM -> IDLE next cycle. lat_out is never asserted mid-abort.
  - Events are ignored with no overrun. plane and row_out hold.
- enable high again: waits for the next event.
- Reset mid-operation: all outputs return to reset values immediately (async). The next event after reset release starts at plane 0.
- busy = (state != IDLE).

Test Plan:
1. Reset, enable=1, defaults. Single latch_in pulse with row_in=5 -> lat_out high 1 cycle at E+5 with row_out=5. oe_n=0 from E+10 for 8 cycles. plane then 1.
2. Four latches spaced 200 cycles apart -> on-times 8, 16, 32, 64. plane sequence 0,1,2,3,0.
3. Second latch arriving 3 cycles after the first event -> overrun pulse 1 cycle. Only one lat_out. row_out equals the first row_in.
4. Latch arriving 5 cycles into ON of plane 2 (32-cycle window) -> oe_n=1 at E+1. ON lasted 5 cycles. New cycle displays plane 3.
5. enable dropped mid-ON -> oe_n=1 next cycle, busy=0 next cycle. Subsequent latches produce no lat_out and no overrun until enable=1.
6. reset asserted during BLANK_POST -> oe_n=1, row_out=0, plane=0 immediately. The next latch sequence is identical to scenario 1.
